// File: rtl/stage_reg_gen_if.sv
// -----------------------------------------------------------------------------
// stage_reg_gen_if
// Purpose : bundles the upstream handshake, downstream handshake, payload
//           and flush of one pipeline stage register so that the stage and its
//           neighbours can be connected with a single port.
// Signals :
//   in_valid / in_ready           upstream handshake (ready driven by the stage)
//   in_pc, in_instr  [31:0]       upstream PC and instruction word
//   in_data [DATA_W-1:0]          upstream payload
//   in_rd   [RD_W-1:0]            upstream destination register index
//   flush                         discard every held entry on the next edge
//   out_valid / out_ready         downstream handshake (valid driven by the stage)
//   out_pc, out_instr, out_data, out_rd   registered payload towards downstream
// Modports:
//   master : the environment (upstream producer + downstream consumer)
//   slave  : the stage register itself
// -----------------------------------------------------------------------------
interface stage_reg_gen_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_pc;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_data;
   logic [RD_W-1:0]   in_rd;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [31:0]       out_instr;
   logic [DATA_W-1:0] out_data;
   logic [RD_W-1:0]   out_rd;

   modport master (
      output in_valid, in_pc, in_instr, in_data, in_rd, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_data, out_rd
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_data, in_rd, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_data, out_rd
   );
endinterface

// File: rtl/stage_reg_gen.sv
// -----------------------------------------------------------------------------
// stage_reg_gen
// Purpose : valid/ready pipeline stage register carrying PC, instruction,
//           payload and destination index bit-exact from input to output.
//           Entries leave in acceptance order. A consumed entry that is not
//           replaced leaves a bubble (instr/data/rd cleared, PC kept). Flush
//           empties the stage and reloads RESET_PC.
// Ports   :
//   i_clk    single clock, all state updated on its rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      stage_reg_gen_if.slave (handshakes, payload, flush)
// Build option:
//   STAGE_REG_SKID_EN  defined   -> two entries (output + skid register),
//                                   in_ready comes straight from a flop
//                      undefined -> one entry, in_ready = !out_valid | out_ready
// -----------------------------------------------------------------------------
module stage_reg_gen #(
   parameter int          DATA_W   = 32,
   parameter int          RD_W     = 5,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic             i_clk,
   input logic             i_rst_n,
   stage_reg_gen_if.slave  bus
);

   // output register
   logic              r_out_valid;
   logic [31:0]       r_out_pc;
   logic [31:0]       r_out_instr;
   logic [DATA_W-1:0] r_out_data;
   logic [RD_W-1:0]   r_out_rd;

   logic              w_out_valid_next;
   logic [31:0]       w_out_pc_next;
   logic [31:0]       w_out_instr_next;
   logic [DATA_W-1:0] w_out_data_next;
   logic [RD_W-1:0]   w_out_rd_next;

   // entry offered to the output register when it frees up
   logic              w_load_valid;
   logic [31:0]       w_load_pc;
   logic [31:0]       w_load_instr;
   logic [DATA_W-1:0] w_load_data;
   logic [RD_W-1:0]   w_load_rd;

   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_out_free;

   // The output slot can take a new value this edge: empty, or being consumed.
   assign w_out_free = !r_out_valid || bus.out_ready;

   // Flush beats a coincident input even when in_ready is high.
   assign w_in_fire  = bus.in_valid && w_in_ready && !bus.flush;

`ifdef STAGE_REG_SKID_EN
   logic              r_skid_valid;
   logic [31:0]       r_skid_pc;
   logic [31:0]       r_skid_instr;
   logic [DATA_W-1:0] r_skid_data;
   logic [RD_W-1:0]   r_skid_rd;

   logic              w_skid_valid_next;
   logic              w_skid_capture;

   // in_ready is the inverted skid flop: no path from out_ready.
   assign w_in_ready = !r_skid_valid;

   // A held skid entry is always older than the input, so it goes first.
   // While the skid is full in_ready is low, so the input cannot compete.
   assign w_load_valid = r_skid_valid || w_in_fire;
   assign w_load_pc    = r_skid_valid ? r_skid_pc    : bus.in_pc;
   assign w_load_instr = r_skid_valid ? r_skid_instr : bus.in_instr;
   assign w_load_data  = r_skid_valid ? r_skid_data  : bus.in_data;
   assign w_load_rd    = r_skid_valid ? r_skid_rd    : bus.in_rd;

   // An input arriving while the output is stalled parks in the skid.
   assign w_skid_capture = w_in_fire && !w_out_free;

   always_comb begin
      w_skid_valid_next = r_skid_valid;
      if (bus.flush) begin
         w_skid_valid_next = 1'b0;
      end else if (w_out_free && r_skid_valid) begin
         w_skid_valid_next = 1'b0;
      end else if (w_skid_capture) begin
         w_skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_skid_valid <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_skid_data  <= '0;
         r_skid_rd    <= '0;
      end else begin
         r_skid_valid <= w_skid_valid_next;
         if (w_skid_capture) begin
            r_skid_pc    <= bus.in_pc;
            r_skid_instr <= bus.in_instr;
            r_skid_data  <= bus.in_data;
            r_skid_rd    <= bus.in_rd;
         end
      end
   end
`else
   // Single entry: accept whenever the output slot frees this edge.
   assign w_in_ready   = w_out_free;
   assign w_load_valid = w_in_fire;
   assign w_load_pc    = bus.in_pc;
   assign w_load_instr = bus.in_instr;
   assign w_load_data  = bus.in_data;
   assign w_load_rd    = bus.in_rd;
`endif

   // Output register next state, shared by both buffering modes.
   always_comb begin
      w_out_valid_next = r_out_valid;
      w_out_pc_next    = r_out_pc;
      w_out_instr_next = r_out_instr;
      w_out_data_next  = r_out_data;
      w_out_rd_next    = r_out_rd;
      if (bus.flush) begin
         w_out_valid_next = 1'b0;
         w_out_pc_next    = RESET_PC;
         w_out_instr_next = '0;
         w_out_data_next  = '0;
         w_out_rd_next    = '0;
      end else if (w_out_free) begin
         if (w_load_valid) begin
            w_out_valid_next = 1'b1;
            w_out_pc_next    = w_load_pc;
            w_out_instr_next = w_load_instr;
            w_out_data_next  = w_load_data;
            w_out_rd_next    = w_load_rd;
         end else begin
            // bubble: PC is left as the last one shown
            w_out_valid_next = 1'b0;
            w_out_instr_next = '0;
            w_out_data_next  = '0;
            w_out_rd_next    = '0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_pc    <= RESET_PC;
         r_out_instr <= '0;
         r_out_data  <= '0;
         r_out_rd    <= '0;
      end else begin
         r_out_valid <= w_out_valid_next;
         r_out_pc    <= w_out_pc_next;
         r_out_instr <= w_out_instr_next;
         r_out_data  <= w_out_data_next;
         r_out_rd    <= w_out_rd_next;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_pc    = r_out_pc;
   assign bus.out_instr = r_out_instr;
   assign bus.out_data  = r_out_data;
   assign bus.out_rd    = r_out_rd;

endmodule

// File: doc/stage_reg_gen.md
STAGE_REG_GEN -- requirements
Module: stage_reg_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the in_data/out_data payload.
REQ-002 The block SHALL have parameter RD_W, default 5, meaning the width of the destination register index.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC value loaded on reset and flush.
REQ-004 The block SHALL have clk  input  1  meaning the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have reset  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have in_valid  input  1  meaning the upstream stage presents a valid instruction.
REQ-007 The block SHALL have in_ready  output  1  meaning the block accepts the input this cycle.
REQ-008 The block SHALL have in_pc/in_instr  input  32 each  meaning the upstream PC and instruction word.
REQ-009 The block SHALL have in_data  input  DATA_W  and in_rd  input  RD_W  meaning the payload and destination index.
REQ-010 The block SHALL have flush  input  1  meaning discard all held entries synchronously.
REQ-011 The block SHALL have out_valid  output  1  and out_ready  input  1  meaning the downstream handshake.
REQ-012 The block SHALL have out_pc, out_instr, out_data and out_rd  outputs  widths as inputs  meaning the registered payload.

Function
REQ-013 A transfer SHALL occur on an input edge when in_valid&in_ready, and on an output edge when out_valid&out_ready.
REQ-014 Latency from an accepted input to out_valid SHALL be exactly 1 cycle when the block is empty.
REQ-015 Sustained throughput SHALL be 1 transfer per cycle while out_ready stays 1.
REQ-016 While out_valid=1 and out_ready=0, all out_* payload signals SHALL hold stable.
REQ-017 When the output entry is consumed and no entry replaces it, the block SHALL load a bubble: out_instr=0, out_rd=0, out_data=0, out_pc unchanged, out_valid=0.
REQ-018 Entries SHALL leave in strict acceptance order, with none dropped or duplicated except on flush.
REQ-019 When flush=1, all entries SHALL be invalidated on the next edge, and out_pc SHALL be set to RESET_PC with the other payload outputs set to 0.
REQ-020 When flush and in_valid coincide, flush SHALL win and the input SHALL be discarded, although in_ready may be 1.
REQ-021 When flush and out_ready coincide, the output entry SHALL count as not transferred.
REQ-022 No payload arithmetic SHALL be performed, and all fields SHALL pass bit-exact.

Reset
REQ-023 When reset=0, the block SHALL asynchronously set out_valid=0, out_pc=RESET_PC, out_instr=0, out_data=0 and out_rd=0, and invalidate any skid entry.
REQ-024 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-025 When reset asserts mid-transfer, the in-flight entry SHALL be lost with no partial update visible.

Configuration
REQ-026 Macro STAGE_REG_SKID_EN SHALL select the buffering mode.
REQ-027 When STAGE_REG_SKID_EN is defined, the block SHALL add a one-entry skid register, drive in_ready directly from a flop as !skid_valid, and have no combinational path from out_ready to in_ready.
REQ-028 When STAGE_REG_SKID_EN is defined, an input accepted while the output is stalled SHALL be stored in the skid register, and on the next consumption the skid entry SHALL move to the output and in_ready SHALL return to 1.
REQ-029 When STAGE_REG_SKID_EN is undefined, the block SHALL hold a single entry and drive in_ready = !out_valid | out_ready combinationally.
REQ-030 External handshake ordering and the reset and flush behaviour SHALL be identical in both modes, and only the in_ready timing and capacity (2 vs 1) SHALL differ.

Verification
REQ-031 The bench SHALL release reset, then apply in_valid=1 with in_pc=0x3004, in_instr=0x8C080004, in_rd=8 and out_ready=1 -> next cycle out_valid=1 with identical fields, and the cycle after (in_valid=0) out_valid=0, out_rd=0, out_pc=0x3004.
REQ-032 The bench SHALL stream 8 back-to-back entries with PC 0x3000..0x301C and out_ready=1 -> 8 consecutive out_valid cycles in order with no gaps.
REQ-033 The bench SHALL hold out_ready=0 with SKID_EN defined and offer 3 entries -> 2 accepted, in_ready=0 from the third cycle, and after out_ready=1 the entries drain in order.
REQ-034 The bench SHALL hold out_ready=0 with SKID_EN undefined -> the second entry is refused, in_ready=0, and out_* stays stable.
REQ-035 The bench SHALL assert flush with the block holding 2 entries and in_valid=1 -> next cycle out_valid=0, out_pc=0x3000, out_instr=0, and no entry later emerges.
REQ-036 The bench SHALL assert reset=0 asynchronously mid-cycle while out_valid=1 -> out_valid falls immediately without a clock edge, out_pc=0x3000, and in_ready=1 after release.
